// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Tracks EX/MEM/WB destinations to drive stalls and operand forwarding.
package hazard_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  typedef struct packed {
    slot_t      s;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_slot_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

endpackage

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   validID,
  input  logic [4:0]             rsID,
  input  logic [4:0]             rtID,
  input  logic                   usesRsID,
  input  logic                   usesRtID,
  input  logic                   branchID,
  input  logic [4:0]             destID,
  input  logic                   regWriteID,
  input  logic                   memReadID,
  output logic                   Stall,
  output logic                   ForwardAD,
  output logic                   ForwardBD,
  output logic [1:0]             ForwardAE,
  output logic [1:0]             ForwardBE,
  output logic [STALL_CNT_W-1:0] stallCount
);

  ex_slot_t ex;
  slot_t    mem;
  slot_t    wb;

  logic load_use;
  logic br_alu;
  logic br_load;
  fwd_t fwd_a;
  fwd_t fwd_b;

  function automatic logic writes(
    input slot_t      s,
    input logic [4:0] r
  );
    return s.valid && s.reg_write &&
           (s.dest == r) && (r != 5'd0);
  endfunction

  // A load in MEM has no data yet, so only WB may supply it.
  function automatic fwd_t fwd_sel(
    input slot_t      m,
    input slot_t      w,
    input logic [4:0] r
  );
    fwd_t sel;
    sel = FWD_RF;
    if (writes(m, r) && !m.mem_read)
      sel = FWD_MEM;
    else if (writes(w, r))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    load_use = 1'b0;
    br_alu   = 1'b0;
    br_load  = 1'b0;
    if (ex.s.mem_read) begin
      load_use = (usesRsID && writes(ex.s, rsID)) ||
                 (usesRtID && writes(ex.s, rtID));
    end
    if (branchID) begin
      br_alu  = writes(ex.s, rsID) ||
                writes(ex.s, rtID);
      br_load = mem.mem_read &&
                (writes(mem, rsID) ||
                 writes(mem, rtID));
    end
  end

  assign Stall = validID &&
                 (load_use || br_alu || br_load);

  assign ForwardAD = branchID &&
                     writes(mem, rsID) &&
                     !mem.mem_read;
  assign ForwardBD = branchID &&
                     writes(mem, rtID) &&
                     !mem.mem_read;

  always_comb begin
    fwd_a = fwd_sel(mem, wb, ex.rs);
    fwd_b = fwd_sel(mem, wb, ex.rt);
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      wb  <= mem;
      mem <= ex.s;
      if (validID && !Stall) begin
        ex.s.valid     <= 1'b1;
        ex.s.dest      <= destID;
        ex.s.reg_write <= regWriteID;
        ex.s.mem_read  <= memReadID;
        ex.rs          <= rsID;
        ex.rt          <= rtID;
      end else begin
        ex <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stallCount <= '0;
    else if (Stall && (stallCount != '1))
      stallCount <= stallCount + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit.
// Covers forwarding, stalls, reset and counter saturation.
module tb_hazard_unit;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       st;
    logic       ad;
    logic       bd;
    logic [1:0] ae;
    logic [1:0] be;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       validID = 1'b0;
  logic [4:0] rsID = '0;
  logic [4:0] rtID = '0;
  logic       usesRsID = 1'b0;
  logic       usesRtID = 1'b0;
  logic       branchID = 1'b0;
  logic [4:0] destID = '0;
  logic       regWriteID = 1'b0;
  logic       memReadID = 1'b0;

  logic        Stall, ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] stallCount;

  logic       s_stall, s_ad, s_bd;
  logic [1:0] s_ae, s_be;
  logic [3:0] s_cnt;

  int pass_cnt = 0;
  int total = 0;
  int exp_cnt = 0;

  vec_t tbl [34];

  always #5 clk = ~clk;

  hazard_unit #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .validID(validID), .rsID(rsID),
    .rtID(rtID), .usesRsID(usesRsID),
    .usesRtID(usesRtID),
    .branchID(branchID), .destID(destID),
    .regWriteID(regWriteID),
    .memReadID(memReadID),
    .Stall(Stall), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
    .stallCount(stallCount)
  );

  hazard_unit #(.STALL_CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .validID(validID), .rsID(rsID),
    .rtID(rtID), .usesRsID(usesRsID),
    .usesRtID(usesRtID),
    .branchID(branchID), .destID(destID),
    .regWriteID(regWriteID),
    .memReadID(memReadID),
    .Stall(s_stall), .ForwardAD(s_ad),
    .ForwardBD(s_bd), .ForwardAE(s_ae),
    .ForwardBE(s_be), .stallCount(s_cnt)
  );

  function automatic vec_t mk(
    input logic v, input int rs, input int rt,
    input logic urs, input logic urt,
    input logic br, input int dest,
    input logic rw, input logic mr,
    input logic st, input logic ad,
    input logic bd, input int ae, input int be
  );
    vec_t x;
    x.v = v; x.rs = 5'(rs); x.rt = 5'(rt);
    x.urs = urs; x.urt = urt; x.br = br;
    x.dest = 5'(dest); x.rw = rw; x.mr = mr;
    x.st = st; x.ad = ad; x.bd = bd;
    x.ae = 2'(ae); x.be = 2'(be);
    return x;
  endfunction

  task automatic drive(input vec_t x);
    validID = x.v; rsID = x.rs; rtID = x.rt;
    usesRsID = x.urs; usesRtID = x.urt;
    branchID = x.br; destID = x.dest;
    regWriteID = x.rw; memReadID = x.mr;
  endtask

  task automatic chk(
    input string name, input int act, input int exp
  );
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d",
                  name, act, exp);
  endtask

  task automatic chk_cnt(input string tag);
    int sat;
    sat = (exp_cnt > 15) ? 15 : exp_cnt;
    chk({tag, " cnt"}, int'(stallCount), exp_cnt);
    chk({tag, " cnt4"}, int'(s_cnt), sat);
  endtask

  vec_t nop, lw2, add_dep, beq32, add2;

  initial begin
    nop     = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    lw2     = mk(1,1,2,1,0,0,2,1,1, 0,0,0,0,0);
    add_dep = mk(1,2,4,1,1,0,3,1,0, 0,0,0,0,0);
    beq32   = mk(1,3,2,1,1,1,0,0,0, 0,0,0,0,0);
    add2    = mk(1,1,1,1,1,0,2,1,0, 0,0,0,0,0);

    tbl[0]  = mk(1,1,2,1,0,0,2,1,1, 0,0,0,0,0);
    tbl[1]  = mk(1,2,4,1,1,0,3,1,0, 1,0,0,0,0);
    tbl[2]  = mk(1,2,4,1,1,0,3,1,0, 0,0,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,0);
    tbl[4]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[5]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[6]  = mk(1,1,1,1,1,0,2,1,0, 0,0,0,0,0);
    tbl[7]  = mk(1,1,1,1,1,0,2,1,0, 0,0,0,0,0);
    tbl[8]  = mk(1,2,2,1,1,0,5,1,0, 0,0,0,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0,2,2);
    tbl[10] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[11] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[12] = mk(1,1,1,1,1,0,2,1,0, 0,0,0,0,0);
    tbl[13] = mk(1,2,3,1,1,1,0,0,0, 1,0,0,0,0);
    tbl[14] = mk(1,2,3,1,1,1,0,0,0, 0,1,0,0,0);
    tbl[15] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,0);
    tbl[16] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[17] = mk(1,1,2,1,0,0,2,1,1, 0,0,0,0,0);
    tbl[18] = mk(1,3,2,1,1,1,0,0,0, 1,0,0,0,0);
    tbl[19] = mk(1,3,2,1,1,1,0,0,0, 1,0,0,0,0);
    tbl[20] = mk(1,3,2,1,1,1,0,0,0, 0,0,0,0,0);
    tbl[21] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[22] = mk(1,1,1,1,1,0,0,1,0, 0,0,0,0,0);
    tbl[23] = mk(1,0,0,1,1,0,3,1,0, 0,0,0,0,0);
    tbl[24] = mk(1,0,0,1,1,1,0,0,0, 0,0,0,0,0);
    tbl[25] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[26] = mk(1,1,0,1,0,0,0,1,1, 0,0,0,0,0);
    tbl[27] = mk(1,0,0,1,1,0,3,1,0, 0,0,0,0,0);
    tbl[28] = mk(1,1,4,1,0,0,4,1,1, 0,0,0,0,0);
    tbl[29] = mk(0,4,0,1,0,0,0,0,0, 0,0,0,0,0);
    tbl[30] = mk(1,1,2,1,0,0,2,1,1, 0,0,0,0,0);
    tbl[31] = mk(1,2,0,0,0,0,5,1,0, 0,0,0,0,0);
    tbl[32] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    tbl[33] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst stall", int'(Stall), 0);
    chk("rst ae", int'(ForwardAE), 0);
    chk("rst be", int'(ForwardBE), 0);
    chk_cnt("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 34; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (i > 0) @(negedge clk);
      drive(tbl[i]);
      #1;
      chk({tag, " stall"}, int'(Stall), int'(tbl[i].st));
      chk({tag, " fad"}, int'(ForwardAD), int'(tbl[i].ad));
      chk({tag, " fbd"}, int'(ForwardBD), int'(tbl[i].bd));
      chk({tag, " fae"}, int'(ForwardAE), int'(tbl[i].ae));
      chk({tag, " fbe"}, int'(ForwardBE), int'(tbl[i].be));
      chk_cnt(tag);
      if (tbl[i].st) exp_cnt++;
    end

    @(negedge clk);
    drive(lw2);
    @(negedge clk);
    drive(add_dep);
    #1;
    chk("pre-rst stall", int'(Stall), 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid-rst stall", int'(Stall), 0);
    chk("mid-rst fad", int'(ForwardAD), 0);
    chk("mid-rst fbd", int'(ForwardBD), 0);
    chk("mid-rst fae", int'(ForwardAE), 0);
    chk("mid-rst fbe", int'(ForwardBE), 0);
    chk_cnt("mid-rst");

    @(negedge clk);
    rst_n = 1'b1;
    drive(lw2);
    #1;
    chk("post-rst stall0", int'(Stall), 0);
    @(negedge clk);
    drive(add_dep);
    #1;
    chk("post-rst load", int'(Stall), 1);
    exp_cnt++;

    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive(lw2);
      #1;
      chk($sformatf("sat%0d lw", k), int'(Stall), 0);
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        drive(beq32);
        #1;
        chk($sformatf("sat%0d beq%0d", k, j),
            int'(Stall), 1);
        exp_cnt++;
      end
    end

    @(negedge clk);
    drive(nop);
    #1;
    chk("sat stall", int'(Stall), 0);
    chk("sat cnt16", int'(stallCount), 19);
    chk("sat cnt4", int'(s_cnt), 15);

    @(negedge clk);
    drive(add2);
    @(negedge clk);
    drive(nop);
    #1;
    chk("sat hold", int'(s_cnt), 15);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard and forwarding controller for the 5-stage MIPS pipeline. It receives the ID-stage decode information and keeps its own shadow copy of the destination-register information held in EX, MEM and WB. From these it produces the ID-stage stall and branch-compare forward selects (inStall, ForwardAD, ForwardBD) that StageID consumes, plus the EX-stage ALU operand forward selects. It also counts stall cycles for performance measurement.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- validID  in  1  ID holds a real instruction; 0 means a bubble or flushed slot.
- rsID  in  5  rs field of the instruction in ID.
- rtID  in  5  rt field of the instruction in ID.
- usesRsID  in  1  the ID instruction reads rs.
- usesRtID  in  1  the ID instruction reads rt.
- branchID  in  1  the ID instruction is beq/bne (compare is done in ID).
- destID  in  5  destination register after RegDst selection.
- regWriteID  in  1  the ID instruction writes the register file.
- memReadID  in  1  the ID instruction is a load.
- Stall  out  1  holds PC and IF/ID and forces a bubble into ID/EX.
- ForwardAD  out  1  branch operand A comes from the EX/MEM ALU result.
- ForwardBD  out  1  branch operand B comes from the EX/MEM ALU result.
- ForwardAE  out  2  EX operand A select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- ForwardBE  out  2  EX operand B select, same encoding as ForwardAE.
- stallCount  out  STALL_CNT_W  number of cycles Stall was asserted; saturates.

## Operation
- Internal slots EX, MEM and WB. Each slot holds: valid, dest, regWrite, memRead. The EX slot also holds rs and rt.
- A slot "writes r" when valid && regWrite && dest==r && r!=0. Register 0 never causes a forward or a stall.
- Pipeline advance, every clock edge:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields when Stall==0 && validID. Otherwise EX <= bubble (valid=0).
- Stall is asserted when any of the following holds:
  - Load-use: EX is a load and writes r, with (usesRsID && rsID==r) or (usesRtID && rtID==r).
  - Branch after ALU op: branchID, and EX writes r where r is rsID or rtID.
  - Branch after load: branchID, and MEM is a load that writes rsID or rtID.
- Stall is forced to 0 when validID==0.
- ForwardAD = branchID && MEM writes rsID && !MEM.memRead. ForwardBD is the same with rtID.
- ForwardAE:
  - 10 if MEM writes EX.rs and !MEM.memRead.
  - else 01 if WB writes EX.rs.
  - else 00.
  - MEM has priority over WB when both match.
- ForwardBE is the same rule applied to EX.rt.
- A load result sitting in MEM is never forwarded from EX/MEM. The load-use stall guarantees it is taken from WB instead.
- stallCount increments on each edge where Stall==1. It holds at all-ones once it reaches that value.

## Timing
- Stall and all forward outputs are combinational from the current slot state plus the ID inputs. There are no registered outputs apart from stallCount.
- Load-use costs exactly 1 stall cycle.
- Branch immediately after a dependent ALU op costs 1 stall cycle.
- Branch immediately after a dependent load costs 2 stall cycles: first on the EX match, then on the MEM match.
- Reset values:
  - All slots invalid.
  - Stall=0, ForwardAD=0, ForwardBD=0, ForwardAE=00, ForwardBE=00, stallCount=0.
- Reset asserted mid-stall clears all state immediately. The first edge after release loads EX from ID.
- Simultaneous load-use and branch hazard produce a single Stall assertion; the counter increments by 1.
- Writeback to a register in the same cycle that ID reads it is not handled here. The register file write-before-read covers it.

## Test plan
- lw $2,0($1) then add $3,$2,$4 -> Stall=1 for 1 cycle, stallCount=1, then ForwardAE=01 for the add in EX.
- add $2,$1,$1 then sub $5,$2,$2 -> no stall; ForwardAE=10 and ForwardBE=10 in sub's EX cycle.
- add $2,.. then beq $2,$3 -> Stall=1 for 1 cycle, then ForwardAD=1 and ForwardBD=0; stallCount=1.
- lw $2,.. then beq $3,$2 -> Stall=1 for 2 consecutive cycles, then ForwardBD=0 (value from the register file after WB); stallCount=2.
- add $0,$1,$1 then add $3,$0,$0 -> Stall=0, ForwardAE=00, ForwardBE=00.
- Hold the load-use condition, pulse rst_n low mid-stall -> all outputs 0 asynchronously. Separately, force 2^16+3 stall cycles -> stallCount=0xFFFF.
